pslip_grant_arb: RTL and testbench
==================================

# pslip_grant_arb

Output-port grant arbiter for the pSLIP switch scheduler. It samples prioritized requests from N input ports and selects the highest-priority level present. Within that level it picks one input by round-robin, using a separate pointer for each priority level. It then holds a one-hot grant until the input side returns an accept/reject response. Pointers advance only on accept, which gives pSLIP desynchronization. This is the output-side partner of the input-side request/priority-select logic, which drives `req_pri` and consumes `grant`.

## Interface
Parameters:
- `N`, 4: number of input ports requesting this output.
- `P`, 4: number of priority codes; `PW = $clog2(P)`. Code 0 means "no request"; higher codes mean higher priority.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req_pri[0:N-1]`  in  PW each  per-input request priority; 0 = not requesting.
- `iter_start`  in  1  one-cycle pulse that starts an arbitration iteration.
- `resp_valid`  in  1  input side returns its decision for the outstanding grant.
- `resp_accept`  in  1  qualified by `resp_valid`: 1 = grant accepted, 0 = grant rejected.
- `grant`  out  N  one-hot grant, held while outstanding.
- `grant_valid`  out  1  a grant is outstanding.
- `grant_pri`  out  PW  priority level of the outstanding grant.
- `busy`  out  1  high in WAIT.

## Operation
States: IDLE, WAIT.

IDLE:
- `iter_start` is ignored unless it is high in IDLE.
- On `iter_start`, sample all `req_pri`.
- `L = max(req_pri[i])`.
- If `L == 0`: stay in IDLE; no grant is issued.
- Otherwise, pick the first index `g` at or after `ptr[L]`, in the order `ptr[L], ptr[L]+1, ..., N-1, 0, ...`, such that `req_pri[g] == L`.
- Register `grant = 1<<g`, `grant_pri = L`, `grant_valid = 1`, and go to WAIT.

WAIT:
- `grant`, `grant_pri` and `grant_valid` are held stable.
- `req_pri` and `iter_start` are ignored.
- On `resp_valid && resp_accept`: `ptr[L] <= (g+1) mod N`, wrapping from N-1 to 0. Clear the grant outputs and go to IDLE.
- On `resp_valid && !resp_accept`: no pointer changes. Clear the grant outputs and go to IDLE.

Pointer rules:
- One pointer per level 1..P-1, each `$clog2(N)` bits.
- Pointer for level 0 is unused.
- Only the pointer of the granted level changes; all other levels keep their value.

General rules:
- `resp_valid` in IDLE is ignored.
- `iter_start` and `resp_valid` in the same WAIT cycle: the response is processed and `iter_start` is dropped. The next iteration needs a new pulse in IDLE.
- When `N` is not a power of two, the pointer wraps at N, not at 2^width.

## Timing
- Reset (`rst_n = 0` at an edge): state = IDLE, `grant = 0`, `grant_valid = 0`, `grant_pri = 0`, `busy = 0`, all pointers = 0.
- Reset dominates every other input.
- Reset asserted in WAIT abandons the grant with no pointer update.
- Grant latency: `iter_start` high at edge k gives a grant visible after edge k, i.e. in cycle k+1.
- Release: `resp_valid` at edge m gives `grant_valid = 0` in cycle m+1. The earliest next `iter_start` is accepted at edge m+1.
- Minimum iteration period is 2 cycles when the response arrives in the first WAIT cycle.
- There is no timeout; the block waits in WAIT indefinitely.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Reset/idle:
  - Apply `rst_n = 0` for 2 cycles, then release. Required: all outputs 0.
  - Pulse `iter_start` with all `req_pri = 0`. Required: `grant_valid` stays 0 and `busy` stays 0.
- Priority select:
  - Set `req_pri = {1,3,2,3}` (inputs 0..3), all pointers 0, and pulse `iter_start`. Required: next cycle `grant = 4'b0010`, `grant_pri = 3`.
- Round-robin on accept:
  - Keep the same requests and accept each grant.
  - Required: successive grants are 0010, 1000, 0010, and `ptr[3]` cycles through 2, 0 (wrap), 2.
  - Required: `ptr[1]` and `ptr[2]` remain 0.
- Reject holds pointer:
  - All four inputs at priority 2; grant 0001 is rejected.
  - Required: the next iteration grants 0001 again. After an accept, the next grant is 0010.
- Collision and ignore rules:
  - In WAIT, pulse `iter_start` with changed `req_pri`. Required: the grant is unchanged.
  - `resp_valid` together with `iter_start`. Required: return to IDLE with no new grant.
  - `resp_valid` asserted in IDLE. Required: no effect.
- Reset mid-operation:
  - Assert `rst_n = 0` in WAIT after pointers have advanced. Required: outputs go to 0 and all pointers return to 0.
  - Then, with `req_pri = {2,2,2,2}`, pulse `iter_start`. Required: grant 0001.

Source files
------------

// File: rtl/pslip_grant_arb.sv
// pslip_grant_arb: output-port grant arbiter for a pSLIP scheduler.
// Picks the highest request priority, then round-robins within that level
// using one pointer per level. The grant is held until the input side
// answers. Pointers move only on accept, which keeps outputs desynchronized.
//
// Handshake: iter_start is a one-cycle pulse that is honoured only in IDLE.
// resp_valid/resp_accept is honoured only in WAIT, where it is consumed on
// the edge that samples it. There is no backpressure on either signal.
module pslip_grant_arb #(
  parameter int N = 4,
  parameter int P = 4,
  localparam int PW = (P > 1) ? $clog2(P) : 1,
  localparam int NW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PW-1:0]   req_pri [N],
  input  logic            iter_start,
  input  logic            resp_valid,
  input  logic            resp_accept,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [PW-1:0]   grant_pri,
  output logic            busy,
  output logic            dbg_state,
  output logic [P*NW-1:0] dbg_ptr
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t          state_q;
  logic [N-1:0]    grant_q;
  logic            grant_valid_q;
  logic [PW-1:0]   grant_pri_q;
  logic [NW-1:0]   gidx_q;
  logic [NW-1:0]   ptr_q [P];

  logic [PW-1:0]   max_pri;
  logic [NW-1:0]   pick_idx;
  logic            found;
  logic [NW:0]     cand;

  // Highest requested level, then the first requester of that level at or
  // after that level's pointer, scanning with wrap at N.
  always_comb begin
    max_pri = '0;
    for (int i = 0; i < N; i++) begin
      if (req_pri[i] > max_pri) max_pri = req_pri[i];
    end
    pick_idx = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q[max_pri]} + (NW+1)'(k);
      if (cand >= (NW+1)'(N)) cand = cand - (NW+1)'(N);
      if (!found && (req_pri[cand[NW-1:0]] == max_pri)) begin
        found    = 1'b1;
        pick_idx = cand[NW-1:0];
      end
    end
  end

  // Arbitration FSM with registered grant outputs and per-level pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_pri_q   <= '0;
      gidx_q        <= '0;
      for (int l = 0; l < P; l++) ptr_q[l] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (iter_start && (max_pri != '0)) begin
            grant_q       <= N'(1) << pick_idx;
            grant_valid_q <= 1'b1;
            grant_pri_q   <= max_pri;
            gidx_q        <= pick_idx;
            state_q       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (resp_valid) begin
            if (resp_accept) begin
              ptr_q[grant_pri_q] <= (gidx_q == NW'(N - 1)) ? '0 : gidx_q + NW'(1);
            end
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_pri_q   <= '0;
            state_q       <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Flatten the pointer array for observation.
  always_comb begin
    dbg_ptr = '0;
    for (int l = 0; l < P; l++) dbg_ptr[l*NW +: NW] = ptr_q[l];
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_pri   = grant_pri_q;
  assign busy        = (state_q == S_WAIT);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pslip_grant_arb.sv
// Bench for pslip_grant_arb: directed steps followed by randomized traffic,
// all checked against a behavioural model of the arbitration rules.
module tb_pslip_grant_arb;

  localparam int N  = 4;
  localparam int P  = 4;
  localparam int PW = 2;
  localparam int NW = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [PW-1:0]   req_pri [N];
  logic            iter_start;
  logic            resp_valid;
  logic            resp_accept;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [PW-1:0]   grant_pri;
  logic            busy;
  logic            dbg_state;
  logic [P*NW-1:0] dbg_ptr;

  pslip_grant_arb #(.N(N), .P(P)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_pri    (req_pri),
    .iter_start (iter_start),
    .resp_valid (resp_valid),
    .resp_accept(resp_accept),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_pri  (grant_pri),
    .busy       (busy),
    .dbg_state  (dbg_state),
    .dbg_ptr    (dbg_ptr)
  );

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  bit m_busy;
  int m_g;
  int m_pri;
  int m_ptr [P];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ptr_of(input int l);
    logic [P*NW-1:0] v;
    v = dbg_ptr;
    return 32'(v[l*NW +: NW]);
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    int lvl;
    if (!rst_n) begin
      m_busy = 0; m_g = 0; m_pri = 0;
      for (int l = 0; l < P; l++) m_ptr[l] = 0;
    end else if (!m_busy) begin
      if (iter_start) begin
        lvl = 0;
        for (int i = 0; i < N; i++) if (int'(req_pri[i]) > lvl) lvl = int'(req_pri[i]);
        if (lvl != 0) begin
          for (int k = 0; k < N; k++) begin
            if (int'(req_pri[(m_ptr[lvl] + k) % N]) == lvl) begin
              m_g = (m_ptr[lvl] + k) % N;
              break;
            end
          end
          m_pri  = lvl;
          m_busy = 1;
        end
      end
    end else if (resp_valid) begin
      if (resp_accept) m_ptr[m_pri] = (m_g + 1) % N;
      m_busy = 0;
    end
  endtask

  // driver: one clock, then compare every output against the model
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("grant_valid", 32'(grant_valid), 32'(m_busy));
    chk("busy",        32'(busy),        32'(m_busy));
    chk("grant",       32'(grant),       m_busy ? (32'd1 << m_g) : 32'd0);
    chk("grant_pri",   32'(grant_pri),   m_busy ? 32'(m_pri) : 32'd0);
    for (int l = 1; l < P; l++) chk("ptr", ptr_of(l), 32'(m_ptr[l]));
  endtask

  task automatic set_req(input int a0, input int a1, input int a2, input int a3);
    req_pri[0] = PW'(a0); req_pri[1] = PW'(a1);
    req_pri[2] = PW'(a2); req_pri[3] = PW'(a3);
  endtask

  task automatic pulse_iter();
    iter_start = 1'b1; cycle(); iter_start = 1'b0;
  endtask

  task automatic respond(input logic acc);
    resp_valid = 1'b1; resp_accept = acc; cycle();
    resp_valid = 1'b0; resp_accept = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; iter_start = 1'b0; resp_valid = 1'b0; resp_accept = 1'b0;
    set_req(0, 0, 0, 0);
    m_busy = 0; m_g = 0; m_pri = 0;
    for (int l = 0; l < P; l++) m_ptr[l] = 0;

    // reset / idle
    cycle(); cycle();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_gv", 32'(grant_valid), 32'd0);
    chk("rst_ptrs", 32'(dbg_ptr), 32'd0);
    rst_n = 1'b1;
    pulse_iter(); cycle();
    chk("idle_no_grant", 32'(grant_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // priority select and round-robin on accept
    set_req(1, 3, 2, 3);
    pulse_iter();
    chk("prio_grant", 32'(grant), 32'h2);
    chk("prio_pri", 32'(grant_pri), 32'd3);
    respond(1'b1);
    chk("rr_ptr3_a", ptr_of(3), 32'd2);
    pulse_iter();
    chk("rr_grant_b", 32'(grant), 32'h8);
    respond(1'b1);
    chk("rr_ptr3_b", ptr_of(3), 32'd0);
    pulse_iter();
    chk("rr_grant_c", 32'(grant), 32'h2);
    respond(1'b1);
    chk("rr_ptr3_c", ptr_of(3), 32'd2);
    chk("rr_ptr1", ptr_of(1), 32'd0);
    chk("rr_ptr2", ptr_of(2), 32'd0);

    // reject holds pointer
    set_req(2, 2, 2, 2);
    pulse_iter();
    chk("rej_first", 32'(grant), 32'h1);
    respond(1'b0);
    pulse_iter();
    chk("rej_again", 32'(grant), 32'h1);
    respond(1'b1);
    pulse_iter();
    chk("rej_after_acc", 32'(grant), 32'h2);
    respond(1'b1);

    // collision and ignore rules
    pulse_iter();
    chk("col_grant", 32'(grant), 32'h4);
    set_req(3, 3, 3, 3);
    pulse_iter();
    chk("col_held", 32'(grant), 32'h4);
    chk("col_pri", 32'(grant_pri), 32'd2);
    iter_start = 1'b1; resp_valid = 1'b1; resp_accept = 1'b1;
    cycle();
    iter_start = 1'b0; resp_valid = 1'b0; resp_accept = 1'b0;
    cycle();
    chk("col_dropped", 32'(grant_valid), 32'd0);
    chk("col_ptr2", ptr_of(2), 32'd3);
    respond(1'b1);
    chk("idle_resp_gv", 32'(grant_valid), 32'd0);
    chk("idle_resp_ptr2", ptr_of(2), 32'd3);

    // reset mid-operation
    pulse_iter();
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    chk("mid_rst_gv", 32'(grant_valid), 32'd0);
    chk("mid_rst_ptrs", 32'(dbg_ptr), 32'd0);
    set_req(2, 2, 2, 2);
    pulse_iter();
    chk("mid_after", 32'(grant), 32'h1);
    respond(1'b1);

    // randomized traffic
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) req_pri[i] = PW'($urandom_range(0, P - 1));
      iter_start  = ($urandom_range(0, 99) < 50);
      resp_valid  = ($urandom_range(0, 99) < 40);
      resp_accept = ($urandom_range(0, 99) < 60);
      rst_n       = ($urandom_range(0, 99) != 0);
      cycle();
    end
    rst_n = 1'b1; iter_start = 1'b0; resp_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
